instr_mem_prog: RTL and testbench
=================================

INSTR_MEM_PROG -- requirements
Module: instr_mem_prog

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, number of stored words; legal range 2..2**ADDR_W.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fetch_req  input  1  fetch request, sampled when fetch_ready=1.
REQ-007 SHALL have port fetch_addr  input  ADDR_W  word address of the fetch.
REQ-008 SHALL have port fetch_ready  output  1  block accepts fetch or program requests this cycle.
REQ-009 SHALL have port instr_out  output  DATA_W  fetched instruction word.
REQ-010 SHALL have port instr_valid  output  1  instr_out holds the data of an accepted fetch.
REQ-011 SHALL have port fault  output  1  accepted fetch addressed a word >= DEPTH; qualified by instr_valid.
REQ-012 SHALL have port prog_en  input  1  write request, sampled when fetch_ready=1.
REQ-013 SHALL have port prog_addr  input  ADDR_W  word address of the write.
REQ-014 SHALL have port prog_data  input  DATA_W  word to write.
REQ-015 SHALL have port prog_ack  output  1  one-cycle pulse confirming a completed write.
REQ-016 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-017 SHALL implement a state machine with states CLEAR, IDLE; CLEAR entered on reset, IDLE entered from CLEAR after the sweep ends.
REQ-018 In CLEAR, SHALL write zero to one word per cycle at addresses 0..DEPTH-1 ascending, drive busy=1, fetch_ready=0, and ignore fetch_req and prog_en.
REQ-019 SHALL enter IDLE the cycle after address DEPTH-1 is cleared; sweep takes exactly DEPTH cycles after reset deasserts.
REQ-020 In IDLE, SHALL drive fetch_ready=1 and busy=0.
REQ-021 An accepted fetch (fetch_req=1, fetch_ready=1) in cycle N SHALL produce instr_valid=1 and instr_out=mem[fetch_addr] in cycle N+1 (one-cycle latency).
REQ-022 SHALL hold instr_valid=0 in any cycle that follows a cycle with no accepted fetch; instr_out SHALL hold its last value.
REQ-023 Back-to-back accepted fetches SHALL sustain one result per cycle.
REQ-024 A fetch with fetch_addr >= DEPTH SHALL return instr_out=0 with fault=1; otherwise fault=0.
REQ-025 An accepted write (prog_en=1, fetch_ready=1) in cycle N SHALL update mem[prog_addr] at that edge and pulse prog_ack=1 in cycle N+1.
REQ-026 A write with prog_addr >= DEPTH SHALL be discarded while still pulsing prog_ack.
REQ-027 Simultaneous accepted fetch and write to the same in-range address SHALL return the new prog_data (write-through bypass).
REQ-028 Simultaneous fetch and write to different addresses SHALL both complete in the same cycle.

Reset
REQ-029 Reset asserted in any cycle SHALL, at the next edge, force instr_valid=0, prog_ack=0, fault=0, instr_out=0, fetch_ready=0, busy=1, state=CLEAR, sweep pointer=0.
REQ-030 Reset held over multiple cycles SHALL keep the sweep pointer at 0; the sweep starts on the first cycle with reset=0.
REQ-031 Reset during a sweep SHALL restart the sweep from address 0.
REQ-032 A fetch or write in the same cycle as reset SHALL be discarded with no ack or valid.

Configuration
REQ-033 Macro IMEM_CLEAR_EN defined SHALL compile in the CLEAR sweep of REQ-018..REQ-019.
REQ-034 Macro IMEM_CLEAR_EN undefined SHALL omit the sweep: reset only clears control outputs (REQ-029 values except busy=0), contents are preserved, and fetch_ready=1 in the first cycle after reset deasserts.

Verification
REQ-035 With IMEM_CLEAR_EN, DEPTH=16: reset 1 cycle, fetch_req held high -> busy=1, fetch_ready=0 for 16 cycles, then fetch_addr=5 -> next cycle instr_valid=1, instr_out=0.
REQ-036 Write addr 3 = 0x38010005, then fetch addr 3 -> prog_ack pulse next cycle; fetch result 0x38010005, fault=0.
REQ-037 Same cycle write addr 7 = 0x00221806 and fetch addr 7 -> instr_out=0x00221806 next cycle.
REQ-038 DEPTH=10: fetch addr 12 -> instr_valid=1, instr_out=0, fault=1; write addr 12 -> prog_ack=1, no memory word changes.
REQ-039 Reset pulsed at sweep cycle 8 of 16 -> busy stays 1, full 16-cycle sweep restarts; fetch_ready rises 16 cycles after reset drops.
REQ-040 Without IMEM_CLEAR_EN: write addr 2 = 0x1234, reset 1 cycle, fetch addr 2 -> fetch_ready=1 first cycle after reset, instr_out=0x1234.

Source files
------------

// File: rtl/instr_mem_prog_if.sv
// Instruction memory fetch/program bus.
//   master: drives fetch_req/fetch_addr and prog_en/prog_addr/prog_data,
//           observes fetch_ready, instr_out, instr_valid, fault, prog_ack, busy.
//   slave : the memory block (instr_mem_prog).
interface instr_mem_prog_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              fault;
  logic              prog_en;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ack;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, prog_en, prog_addr, prog_data,
    input  fetch_ready, instr_out, instr_valid, fault, prog_ack, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, prog_en, prog_addr, prog_data,
    output fetch_ready, instr_out, instr_valid, fault, prog_ack, busy
  );
endinterface

// File: rtl/instr_mem_prog.sv
// Programmable instruction memory with one-cycle registered fetch.
//   clk   : sole clock, rising edge
//   reset : synchronous, active high
//   bus   : instr_mem_prog_if.slave
//     fetch_req/fetch_addr -> instr_out/instr_valid/fault (next cycle)
//     prog_en/prog_addr/prog_data -> prog_ack (next cycle)
//     fetch_ready : requests accepted this cycle; busy : clear sweep running
// Build option: define IMEM_CLEAR_EN to zero the whole array after every
// reset (DEPTH cycles, busy=1). Without it, reset leaves contents intact and
// the block is ready in the first cycle after reset deasserts.
module instr_mem_prog #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic             clk,
  input logic             reset,
  instr_mem_prog_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t state, state_nx;
  logic   busy_c, ready_c;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] instr_out_q;
  logic              instr_valid_q, fault_q, prog_ack_q;

  logic fetch_acc, prog_acc, fetch_in, prog_in, bypass;

`ifdef IMEM_CLEAR_EN
  localparam state_t            RESET_STATE = CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] sweep_ptr;

  // Pointer sits at 0 outside the sweep so a reset mid-sweep restarts it.
  always_ff @(posedge clk) begin
    if (reset || state != CLEAR) sweep_ptr <= '0;
    else                         sweep_ptr <= sweep_ptr + 1'b1;
  end
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
`ifdef IMEM_CLEAR_EN
      CLEAR:   if (sweep_ptr == LAST_ADDR) state_nx = IDLE;
`else
      CLEAR:   state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Output logic; ready is masked by reset so nothing is accepted in a reset cycle
  always_comb begin
    busy_c  = (state == CLEAR);
    ready_c = (state == IDLE) && !reset;
  end

  assign fetch_acc = bus.fetch_req && ready_c;
  assign prog_acc  = bus.prog_en   && ready_c;
  assign fetch_in  = {1'b0, bus.fetch_addr} < DEPTH_V;
  assign prog_in   = {1'b0, bus.prog_addr}  < DEPTH_V;
  assign bypass    = prog_acc && prog_in && (bus.prog_addr == bus.fetch_addr);

  // Storage: no reset so contents survive reset when the sweep is not built
  always_ff @(posedge clk) begin
`ifdef IMEM_CLEAR_EN
    if (!reset && state == CLEAR) mem[sweep_ptr[IDX_W-1:0]] <= '0;
    else
`endif
    if (prog_acc && prog_in) mem[bus.prog_addr[IDX_W-1:0]] <= bus.prog_data;
  end

  // Fetch result and write acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid_q <= 1'b0;
      prog_ack_q    <= 1'b0;
      fault_q       <= 1'b0;
      instr_out_q   <= '0;
    end else begin
      instr_valid_q <= fetch_acc;
      prog_ack_q    <= prog_acc;
      fault_q       <= fetch_acc && !fetch_in;
      if (fetch_acc) begin
        if (!fetch_in)   instr_out_q <= '0;
        else if (bypass) instr_out_q <= bus.prog_data;
        else             instr_out_q <= mem[bus.fetch_addr[IDX_W-1:0]];
      end
    end
  end

  assign bus.fetch_ready = ready_c;
  assign bus.busy        = busy_c;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fault       = fault_q;
  assign bus.prog_ack    = prog_ack_q;
endmodule

// File: tb/tb_instr_mem_prog.sv
// Testbench for instr_mem_prog (DEPTH=10, ADDR_W=4). Works in either build
// of IMEM_CLEAR_EN; the reference model picks the matching reset behaviour.
module tb_instr_mem_prog;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 10;
  localparam int NWORDS = 1 << ADDR_W;
`ifdef IMEM_CLEAR_EN
  localparam int CLEAR_CYCLES = DEPTH;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_mem_prog_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_prog #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: array contents plus "sweep cycles still to go"
  logic [DATA_W-1:0] ref_mem   [NWORDS];
  bit                ref_known [NWORDS];
  int                remaining = 0;
  logic [DATA_W-1:0] e_out     = '0;
  bit                out_known = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational status, predict,
  // advance the clock, check registered results.
  task automatic cycle(input logic r, input logic fr, input logic [ADDR_W-1:0] fa,
                       input logic pe, input logic [ADDR_W-1:0] pa,
                       input logic [DATA_W-1:0] pd);
    bit exp_ready, facc, pacc, e_valid, e_ack, e_fault;
    reset = r;
    bus.fetch_req = fr; bus.fetch_addr = fa;
    bus.prog_en = pe; bus.prog_addr = pa; bus.prog_data = pd;
    #1;
    exp_ready = !r && (remaining == 0);
    check_eq("fetch_ready", 64'(bus.fetch_ready), 64'(exp_ready));
    if (!r) check_eq("busy", 64'(bus.busy), 64'(remaining != 0));
    facc = exp_ready && fr;
    pacc = exp_ready && pe;
    e_valid = 0; e_ack = 0; e_fault = 0;
    if (r) begin
      e_out = '0; out_known = 1;
    end else begin
      e_valid = facc;
      e_ack   = pacc;
      if (facc) begin
        e_fault = (int'(fa) >= DEPTH);
        if (e_fault) begin
          e_out = '0; out_known = 1;
        end else if (pacc && pa == fa) begin
          e_out = pd; out_known = 1;
        end else begin
          e_out = ref_mem[fa]; out_known = ref_known[fa];
        end
      end
    end
    if (r) remaining = CLEAR_CYCLES;
    else if (remaining > 0) begin
      ref_mem[DEPTH - remaining]   = '0;
      ref_known[DEPTH - remaining] = 1;
      remaining--;
    end else if (pacc && int'(pa) < DEPTH) begin
      ref_mem[pa]   = pd;
      ref_known[pa] = 1;
    end
    @(posedge clk); #1;
    check_eq("instr_valid", 64'(bus.instr_valid), 64'(e_valid));
    check_eq("prog_ack", 64'(bus.prog_ack), 64'(e_ack));
    if (e_valid || r) check_eq("fault", 64'(bus.fault), 64'(e_fault));
    if (out_known) check_eq("instr_out", 64'(bus.instr_out), 64'(e_out));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 4'd5, 1'b1, 4'd5, 32'hDEAD_BEEF);
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    cycle(1'b0, 1'b1, a, 1'b0, '0, '0);
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cycle(1'b0, 1'b0, '0, 1'b1, a, d);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64 && remaining > 0; i++)
      cycle(1'b0, 1'b1, 4'd5, 1'b1, 4'd1, 32'h1111_1111);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      ref_mem[i] = '0;
      ref_known[i] = 0;
    end

    // Reset with requests pending (discarded), then sweep with fetch held
    do_reset();
    wait_ready();
    fetch(4'd5);

    // Write then fetch; same-cycle write+fetch bypass; different addresses
    write(4'd3, 32'h3801_0005);
    fetch(4'd3);
    cycle(1'b0, 1'b1, 4'd7, 1'b1, 4'd7, 32'h0022_1806);
    idle();
    cycle(1'b0, 1'b1, 4'd3, 1'b1, 4'd4, 32'hCAFE_0004);
    fetch(4'd4);

    // Out-of-range fetch and write; back-to-back reads show no word changed
    fetch(4'd12);
    write(4'd12, 32'hFFFF_FFFF);
    for (int a = 0; a < NWORDS; a++) fetch(ADDR_W'(a));

    // Contents across a single-cycle reset
    write(4'd2, 32'h0000_1234);
    do_reset();
    fetch(4'd2);
    wait_ready();
    fetch(4'd2);

    // Reset held two cycles, then reset pulsed mid-sweep
    do_reset();
    do_reset();
    for (int i = 0; i < 8; i++) idle();
    do_reset();
    wait_ready();
    fetch(4'd9);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [ADDR_W-1:0] fa, pa;
      fa = ADDR_W'($urandom_range(0, NWORDS - 1));
      pa = ($urandom_range(0, 3) == 0) ? fa : ADDR_W'($urandom_range(0, NWORDS - 1));
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), fa, 1'($urandom), pa, $urandom);
    end
    wait_ready();
    for (int a = 0; a < NWORDS; a++) fetch(ADDR_W'(a));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
